store_ctrl: RTL

Sequences RV32I store instructions onto the data-memory write port. Accepts one decoded store (`store_kind_t`), address and data from the execute stage, then:
- checks alignment;
- builds byte strobes and lane-replicated write data;
- runs a req/ack handshake with memory, with a bus timeout;
- reports completion or fault back to the pipeline.

It sits between the store decoder's output and the data-memory interface, and it is the only driver of memory writes.

---
 rtl/store_ctrl_pkg.sv | 18 +
 rtl/store_ctrl_if.sv | 32 +++
 rtl/store_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/store_ctrl_pkg.sv
// Shared types for the store sequencer.
//   store_kind_t : decoded RV32I store flavour handed over by the store decoder.
//   CAUSE_*      : encodings driven on fault_cause while fault is pulsed.
package store_ctrl_pkg;

  typedef enum logic [1:0] {
    sk_sb      = 2'd0,
    sk_sh      = 2'd1,
    sk_sw      = 2'd2,
    sk_invalid = 2'd3
  } store_kind_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_KIND    = 2'd1;
  localparam logic [1:0] CAUSE_ALIGN   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/store_ctrl_if.sv
// Data-memory write port between the store sequencer and memory.
//   mem_req   : write request, held until mem_ack or timeout
//   mem_addr  : word-aligned address
//   mem_wdata : lane-replicated write data
//   mem_wstrb : byte enables
//   mem_ack   : memory accepted the write
// master = store_ctrl side, slave = memory side.
interface store_ctrl_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ack
  );

endinterface

// File: rtl/store_ctrl.sv
// store_ctrl: sequences one RV32I store at a time onto the data-memory
// write port. Checks alignment, builds byte strobes and lane-replicated
// data, runs a req/ack handshake with a bus timeout and reports done/fault.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   issue_valid/ready store handshake from the execute stage
//   kind, addr, data  decoded store kind, byte address, rs2 value
//   mem               data-memory write port (store_ctrl_if.master)
//   done              one-cycle pulse, store completed
//   fault             one-cycle pulse, store rejected or aborted
//   fault_cause       1 invalid kind, 2 misaligned, 3 bus timeout, else 0
//
// Every output comes straight from a register.
module store_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16  // 0 disables the bus timeout
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  store_kind_t        kind,
  input  logic [31:0]        addr,
  input  logic [31:0]        data,
  store_ctrl_if.master       mem,
  output logic               done,
  output logic               fault,
  output logic [1:0]         fault_cause
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // All architectural state in one record so reset and next-state are
  // handled in exactly one place each.
  typedef struct packed {
    state_t           state;
    logic             ready;
    logic             req;
    logic [31:0]      maddr;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             done;
    logic             fault;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;
  } regs_t;

  localparam regs_t RESET_REGS = '{
    state: IDLE,
    ready: 1'b1,
    req:   1'b0,
    maddr: 32'h0,
    wdata: 32'h0,
    wstrb: 4'h0,
    done:  1'b0,
    fault: 1'b0,
    cause: CAUSE_NONE,
    cnt:   '0
  };

  regs_t q;
  regs_t d;

  logic [3:0]       lane_strb;
  logic [31:0]      lane_data;
  logic             misaligned;
  logic [CNT_W-1:0] cnt_next;

  // Lane steering for the presented store; only consumed when it is accepted.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves it unassigned (which would infer a latch).
    lane_strb  = 4'b0000;
    lane_data  = 32'h0;
    misaligned = 1'b0;
    case (kind)
      sk_sb: begin
        lane_strb = 4'b0001 << addr[1:0];
        lane_data = {4{data[7:0]}};
      end
      sk_sh: begin
        misaligned = addr[0];
        lane_strb  = addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{data[15:0]}};
      end
      sk_sw: begin
        misaligned = |addr[1:0];
        lane_strb  = 4'b1111;
        lane_data  = data;
      end
      default: ;
    endcase
  end

  // Saturating so a disabled timeout can never wrap back into a match.
  assign cnt_next = (q.cnt == CNT_MAX) ? q.cnt : q.cnt + CNT_W'(1);

  always_comb begin
    d       = q;
    d.done  = 1'b0;
    d.fault = 1'b0;
    d.cause = CAUSE_NONE;
    case (q.state)
      IDLE: begin
        if (issue_valid && q.ready) begin
          if (kind == sk_invalid) begin
            d.fault = 1'b1;
            d.cause = CAUSE_KIND;
          end else if (misaligned) begin
            d.fault = 1'b1;
            d.cause = CAUSE_ALIGN;
          end else begin
            d.state = REQ;
            d.ready = 1'b0;
            d.req   = 1'b1;
            d.maddr = {addr[31:2], 2'b00};
            d.wdata = lane_data;
            d.wstrb = lane_strb;
            d.cnt   = '0;
          end
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a timeout expiring on the
        // same edge.
        if (mem.mem_ack) begin
          d.state = IDLE;
          d.ready = 1'b1;
          d.req   = 1'b0;
          d.wdata = 32'h0;
          d.wstrb = 4'h0;
          d.done  = 1'b1;
        end else begin
          d.cnt = cnt_next;
          if (TIMEOUT_CYCLES != 0 && cnt_next == CNT_LIMIT) begin
            d.state = IDLE;
            d.ready = 1'b1;
            d.req   = 1'b0;
            d.wdata = 32'h0;
            d.wstrb = 4'h0;
            d.fault = 1'b1;
            d.cause = CAUSE_TIMEOUT;
          end
        end
      end
      default: d = RESET_REGS;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so every register
    // samples pre-edge values. The datapath registers are reset too, since
    // they drive the memory port directly and must read 0 out of reset.
    if (!rst) q <= RESET_REGS;
    else      q <= d;
  end

  assign issue_ready   = q.ready;
  assign mem.mem_req   = q.req;
  assign mem.mem_addr  = q.maddr;
  assign mem.mem_wdata = q.wdata;
  assign mem.mem_wstrb = q.wstrb;
  assign done          = q.done;
  assign fault         = q.fault;
  assign fault_cause   = q.cause;

endmodule
